musk_arb: RTL and testbench

MUSK_ARB -- requirements
Module: musk_arb

---
 rtl/musk_arb_pkg.sv | 24 ++
 rtl/Muskbus.sv | 25 ++
 rtl/musk_arb_rr.sv | 51 +++++
 rtl/musk_arb.sv | 157 +++++++++++++++
 tb/tb_musk_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/musk_arb_pkg.sv
// Shared types and constants for the two-requester Muskbus arbiter.
// Holds the FSM state enum, the write-flag tag bit and default beat counts.
package musk_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WRITE_BIT          = 12;
  localparam int TAG_W              = 13;
  localparam int DATA_W             = 64;
  localparam int DEFAULT_RESP_BEATS = 8;
  localparam int DEFAULT_WR_BEATS   = 8;

  // Wide enough to hold the longest transaction's beat count without wrapping.
  function automatic int beat_cnt_width(input int wrBeats, input int respBeats);
    int maxBeats;
    maxBeats = ((1 + wrBeats) > respBeats) ? (1 + wrBeats) : respBeats;
    return $clog2(maxBeats + 1);
  endfunction

endpackage

// File: rtl/Muskbus.sv
// Muskbus point-to-point bundle; Top is the arbiter's view of a requester,
// Bottom is the arbiter's view of the downstream memory.
interface Muskbus;
  import musk_arb_pkg::*;

  logic              bid;
  logic [DATA_W-1:0] req;
  logic [TAG_W-1:0]  reqtag;
  logic              reqcyc;
  logic              reqack;
  logic [DATA_W-1:0] resp;
  logic              respcyc;
  logic              respack;

  modport Top (
    input  bid, req, reqtag, reqcyc, respack,
    output reqack, resp, respcyc
  );

  modport Bottom (
    output bid, req, reqtag, reqcyc, respack,
    input  reqack, resp, respcyc
  );

endinterface

// File: rtl/musk_arb_rr.sv
// Two-way tie-break picker with a last-granted pointer register.
// With MUSK_ARB_FIXED_PRIO_EN defined, requester 0 always wins ties and the pointer is dropped.
module musk_arb_rr (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       owner_i,
  output logic       valid_o,
  output logic       idx_o
);

`ifdef MUSK_ARB_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^{clk_i, rst_ni, update_i, owner_i};

  assign valid_o = |req_i;
  assign idx_o   = ~req_i[0];

`else

  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = owner_i;
    end
  end

  // Reset pretends requester 1 was served last so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    valid_o = |req_i;
    idx_o   = req_i[1];
    if (req_i == 2'b11) begin
      idx_o = ~last_q;
    end
  end

`endif

endmodule

// File: rtl/musk_arb.sv
// Two-requester Muskbus arbiter: IDLE -> REQ -> (RESP) -> IDLE, one transaction at a time.
// Tie-break policy is round-robin unless MUSK_ARB_FIXED_PRIO_EN is defined.
module musk_arb
  import musk_arb_pkg::*;
#(
  parameter int RESP_BEATS = DEFAULT_RESP_BEATS,
  parameter int WR_BEATS   = DEFAULT_WR_BEATS
) (
  input  logic       clk,
  input  logic       reset_n,
  Muskbus.Top        m0,
  Muskbus.Top        m1,
  Muskbus.Bottom     mem,
  output logic [1:0] gnt
);

  localparam int               CNT_W     = beat_cnt_width(WR_BEATS, RESP_BEATS);
  localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_BEATS);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_BEATS - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pickValid;
  logic              pickIdx;
  logic              txnDone;

  logic              ownReqcyc;
  logic              ownRespack;
  logic [DATA_W-1:0] ownReq;
  logic [TAG_W-1:0]  ownReqtag;

  musk_arb_rr u_rr (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .req_i    ({m1.bid, m0.bid}),
    .update_i (txnDone),
    .owner_i  (owner_q),
    .valid_o  (pickValid),
    .idx_o    (pickIdx)
  );

  always_comb begin
    ownReqcyc  = owner_q ? m1.reqcyc  : m0.reqcyc;
    ownRespack = owner_q ? m1.respack : m0.respack;
    ownReq     = owner_q ? m1.req     : m0.req;
    ownReqtag  = owner_q ? m1.reqtag  : m0.reqtag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
    end
  end

  // The grant is held until the beat count completes, whatever bid/reqcyc do meanwhile.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    txnDone = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          owner_d = pickIdx;
          write_d = pickIdx ? m1.reqtag[WRITE_BIT] : m0.reqtag[WRITE_BIT];
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ownReqcyc && mem.reqack) begin
          if (!write_q) begin
            cnt_d   = '0;
            state_d = RESP;
          end else if (cnt_q == WR_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            txnDone = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESP: begin
        if (mem.respcyc && ownRespack) begin
          if (cnt_q == RESP_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            txnDone = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Everything defaults to zero, so IDLE and the non-owner see a quiet bus.
  always_comb begin
    gnt         = 2'b00;
    mem.bid     = 1'b0;
    mem.req     = '0;
    mem.reqtag  = '0;
    mem.reqcyc  = 1'b0;
    mem.respack = 1'b0;
    m0.reqack   = 1'b0;
    m0.resp     = '0;
    m0.respcyc  = 1'b0;
    m1.reqack   = 1'b0;
    m1.resp     = '0;
    m1.respcyc  = 1'b0;
    case (state_q)
      REQ: begin
        gnt        = owner_q ? 2'b10 : 2'b01;
        mem.bid    = 1'b1;
        mem.req    = ownReq;
        mem.reqtag = ownReqtag;
        mem.reqcyc = ownReqcyc;
        if (owner_q) begin
          m1.reqack = mem.reqack;
        end else begin
          m0.reqack = mem.reqack;
        end
      end
      RESP: begin
        gnt         = owner_q ? 2'b10 : 2'b01;
        mem.bid     = 1'b1;
        mem.respack = ownRespack;
        if (owner_q) begin
          m1.resp    = mem.resp;
          m1.respcyc = mem.respcyc;
        end else begin
          m0.resp    = mem.resp;
          m0.respcyc = mem.respcyc;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_musk_arb.sv
// Self-checking bench for musk_arb: randomized traffic checked against a transaction-level model.
// Define MUSK_ARB_FIXED_PRIO_EN for both DUT and bench to check fixed-priority ties.
module tb_musk_arb;
  import musk_arb_pkg::*;

  localparam int RB = 8;
  localparam int WB = 8;

  logic       clk;
  logic       reset_n;
  logic [1:0] gnt;

  Muskbus m0_if ();
  Muskbus m1_if ();
  Muskbus mem_if ();

  musk_arb #(.RESP_BEATS(RB), .WR_BEATS(WB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .mem     (mem_if),
    .gnt     (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt   = 0;
  int totalCnt  = 0;
  int lastOwner = 1;

  logic        bidV     [2];
  logic        reqcycV  [2];
  logic        respackV [2];
  logic [63:0] reqData  [2];
  logic [12:0] reqTag   [2];

  function automatic logic [1:0] oh(input int idx);
    return (idx == 0) ? 2'b01 : 2'b10;
  endfunction

  // Model of the arbitration rule: lone bidder wins, ties go to whoever was not served last.
  function automatic int expect_winner(input logic b0, input logic b1);
    if (b0 && b1) begin
`ifdef MUSK_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (lastOwner == 0) ? 1 : 0;
`endif
    end
    return b0 ? 0 : 1;
  endfunction

  task automatic drive_req();
    m0_if.bid     = bidV[0];
    m0_if.req     = reqData[0];
    m0_if.reqtag  = reqTag[0];
    m0_if.reqcyc  = reqcycV[0];
    m0_if.respack = respackV[0];
    m1_if.bid     = bidV[1];
    m1_if.req     = reqData[1];
    m1_if.reqtag  = reqTag[1];
    m1_if.reqcyc  = reqcycV[1];
    m1_if.respack = respackV[1];
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      bidV[i]     = 1'b0;
      reqcycV[i]  = 1'b0;
      respackV[i] = 1'b0;
      reqData[i]  = '0;
      reqTag[i]   = '0;
    end
    mem_if.reqack  = 1'b0;
    mem_if.resp    = '0;
    mem_if.respcyc = 1'b0;
    drive_req();
  endtask

  task automatic set_req(input int idx, input logic [12:0] tag, input logic [63:0] data);
    bidV[idx]     = 1'b1;
    reqcycV[idx]  = 1'b1;
    respackV[idx] = 1'b1;
    reqTag[idx]   = tag;
    reqData[idx]  = data;
    drive_req();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_all();
    lastOwner = 1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Plays the memory for one transaction owned by 'own', checking routing every cycle.
  task automatic serve_txn(input int own, input int gapMin, input int gapMax, input int dropAfter,
                           input int abortAfter, input bit randCyc, input logic [63:0] base,
                           output int obsOwner, output int fwdBeats);
    int          t, phase, beats, k, waitCnt, gap, target, oth;
    logic        ack, cyc;
    logic [83:0] obsReq, expReq;
    logic [4:0]  obsResp, expResp;
    logic [127:0] obsData, expData;
    logic [8:0]  obsIdle;
    logic [63:0] noise;
    oth      = 1 - own;
    fwdBeats = 0;
    t        = 0;
    mem_if.reqack  = 1'b0;
    mem_if.respcyc = 1'b0;
    while (gnt === 2'b00 && t < 50) begin
      @(negedge clk);
      t++;
    end
    obsOwner = (gnt === 2'b10) ? 1 : ((gnt === 2'b01) ? 0 : -1);
    totalCnt++;
    if (gnt !== oh(own)) begin
      $display("[TB] FAIL grant: gnt=%b expected=%b", gnt, oh(own));
      return;
    end
    passCnt++;
    target  = reqTag[own][WRITE_BIT] ? 1 + WB : 1;
    phase   = 0;
    beats   = 0;
    k       = 0;
    waitCnt = 0;
    gap     = int'($urandom_range(gapMin, gapMax));
    for (int c = 0; c < 400; c++) begin
      noise = {$urandom, $urandom};
      cyc   = randCyc ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (phase == 0) begin
        reqcycV[own]   = cyc;
        respackV[own]  = 1'b1;
        ack            = (waitCnt >= gap);
        mem_if.reqack  = ack;
        mem_if.respcyc = 1'($urandom_range(0, 1));
        mem_if.resp    = noise;
      end else begin
        ack            = 1'($urandom_range(0, 1));
        mem_if.reqack  = ack;
        mem_if.respcyc = cyc;
        mem_if.resp    = cyc ? base + 64'(k) : noise;
        respackV[own]  = randCyc ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      drive_req();
      #1;
      totalCnt++;
      if (gnt !== oh(own)) $display("[TB] FAIL hold_grant: gnt=%b expected=%b", gnt, oh(own));
      else passCnt++;
      if (phase == 0) begin
        obsReq = {mem_if.bid, mem_if.reqcyc, mem_if.reqtag, mem_if.req, m0_if.reqack, m1_if.reqack,
                  m0_if.respcyc, m1_if.respcyc, mem_if.respack};
        expReq = {1'b1, cyc, reqTag[own], reqData[own], (own == 0) && ack, (own == 1) && ack, 3'b000};
        totalCnt++;
        if (obsReq !== expReq) $display("[TB] FAIL req_route: got=%h expected=%h", obsReq, expReq);
        else passCnt++;
        if (mem_if.reqcyc === 1'b1 && ack) fwdBeats++;
        if (cyc && ack) begin
          beats++;
          waitCnt = 0;
          gap     = int'($urandom_range(gapMin, gapMax));
          if (beats == target) phase = reqTag[own][WRITE_BIT] ? 2 : 1;
        end else begin
          waitCnt++;
        end
      end else begin
        obsResp = {mem_if.bid,
                   (oth == 0) ? m0_if.reqack  : m1_if.reqack,
                   (own == 0) ? m0_if.respcyc : m1_if.respcyc,
                   (oth == 0) ? m0_if.respcyc : m1_if.respcyc,
                   mem_if.respack};
        expResp = {1'b1, 1'b0, cyc, 1'b0, respackV[own]};
        totalCnt++;
        if (obsResp !== expResp) $display("[TB] FAIL resp_route: got=%b expected=%b", obsResp, expResp);
        else passCnt++;
        if (cyc) begin
          obsData = (own == 0) ? {m0_if.resp, m1_if.resp} : {m1_if.resp, m0_if.resp};
          expData = {base + 64'(k), 64'h0};
          totalCnt++;
          if (obsData !== expData) $display("[TB] FAIL resp_data: got=%h expected=%h", obsData, expData);
          else passCnt++;
        end
        if (cyc && respackV[own]) begin
          k++;
          if (k == dropAfter) bidV[own] = 1'b0;
          if (k == abortAfter) return;
          if (k == RB) phase = 2;
        end
      end
      @(negedge clk);
      if (phase == 2) begin
        mem_if.reqack  = 1'b0;
        mem_if.respcyc = 1'b0;
        bidV[own]      = 1'b0;
        reqcycV[own]   = 1'b0;
        drive_req();
        #1;
        obsIdle = {gnt, mem_if.bid, mem_if.reqcyc, mem_if.respack, m0_if.reqack, m1_if.reqack,
                   m0_if.respcyc, m1_if.respcyc};
        totalCnt++;
        if (obsIdle !== 9'b0) $display("[TB] FAIL txn_end_idle: got=%b expected=000000000", obsIdle);
        else passCnt++;
        lastOwner = own;
        return;
      end
    end
    totalCnt++;
    $display("[TB] FAIL txn_timeout: owner=%0d beats=%0d resp=%0d expected completion", own, beats, k);
  endtask

  task automatic test_reset();
    int          obs, fwd;
    logic [8:0]  v;
    reset_n = 1'b0;
    clear_all();
    set_req(0, 13'h0002, 64'h1111_2222_3333_4444);
    mem_if.respcyc = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    v = {gnt, mem_if.bid, mem_if.reqcyc, mem_if.respack, m0_if.reqack, m1_if.reqack,
         m0_if.respcyc, m1_if.respcyc};
    totalCnt++;
    if (v !== 9'b0 || (|{mem_if.req, mem_if.reqtag, m0_if.resp, m1_if.resp}) !== 1'b0)
      $display("[TB] FAIL reset_outputs: got=%b expected=000000000 and zero buses", v);
    else passCnt++;
    mem_if.respcyc = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    lastOwner = 1;
    #1;
    totalCnt++;
    if (gnt !== 2'b00) $display("[TB] FAIL release_idle: gnt=%b expected=00", gnt);
    else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (gnt !== 2'b01) $display("[TB] FAIL first_arb: gnt=%b expected=01", gnt);
    else passCnt++;
    serve_txn(0, 0, 1, -1, -1, 1'b0, 64'h10, obs, fwd);
  endtask

  task automatic test_single_read();
    int obs, fwd;
    set_req(0, 13'h0001, 64'hDEAD_BEEF_0000_0001);
    serve_txn(0, 1, 1, -1, -1, 1'b0, 64'hA0, obs, fwd);
    totalCnt++;
    if (fwd !== 1) $display("[TB] FAIL read_addr_beats: got=%0d expected=1", fwd);
    else passCnt++;
  endtask

  task automatic test_write();
    int obs, fwd;
    set_req(1, 13'h1000, 64'h0BAD_CAFE_0000_0002);
    serve_txn(expect_winner(1'b0, 1'b1), 3, 3, -1, -1, 1'b0, 64'h0, obs, fwd);
    totalCnt++;
    if (fwd !== 1 + WB) $display("[TB] FAIL write_beats: got=%0d expected=%0d", fwd, 1 + WB);
    else passCnt++;
  endtask

  task automatic test_tie();
    int         obs, fwd, exp;
    logic [3:0] order, expOrder;
`ifdef MUSK_ARB_FIXED_PRIO_EN
    expOrder = 4'b0000;
`else
    expOrder = 4'b1010;
`endif
    apply_reset();
    order = 4'b0;
    for (int r = 0; r < 4; r++) begin
      set_req(0, {1'b0, 12'($urandom)}, {$urandom, $urandom});
      set_req(1, {1'b0, 12'($urandom)}, {$urandom, $urandom});
      exp = expect_winner(1'b1, 1'b1);
      serve_txn(exp, 1, 1, -1, -1, 1'b0, 64'(r) << 8, obs, fwd);
      order[r]         = (obs == 1);
      bidV[1 - exp]    = 1'b0;
      reqcycV[1 - exp] = 1'b0;
      drive_req();
    end
    totalCnt++;
    if (order !== expOrder) $display("[TB] FAIL tie_order: got=%b expected=%b", order, expOrder);
    else passCnt++;
  endtask

  task automatic test_drop_bid();
    int obs, fwd, exp;
    set_req(0, 13'h0011, 64'h5555_0000_0000_0000);
    set_req(1, 13'h0022, 64'h6666_0000_0000_0000);
    exp = expect_winner(1'b1, 1'b1);
    serve_txn(exp, 0, 1, 2, -1, 1'b0, 64'hB0, obs, fwd);
    serve_txn(expect_winner(bidV[0], bidV[1]), 0, 1, -1, -1, 1'b0, 64'hD0, obs, fwd);
  endtask

  task automatic test_reset_mid();
    int         obs, fwd;
    logic [8:0] v;
    set_req(0, 13'h0004, 64'h2222_0000_0000_0000);
    serve_txn(expect_winner(1'b1, 1'b0), 0, 1, -1, 3, 1'b0, 64'hE0, obs, fwd);
    @(posedge clk);
    #2;
    mem_if.respcyc = 1'b1;
    reset_n        = 1'b0;
    #1;
    v = {gnt, mem_if.bid, mem_if.reqcyc, mem_if.respack, m0_if.reqack, m1_if.reqack,
         m0_if.respcyc, m1_if.respcyc};
    totalCnt++;
    if (v !== 9'b0) $display("[TB] FAIL reset_mid_outputs: got=%b expected=000000000", v);
    else passCnt++;
    lastOwner = 1;
    clear_all();
    @(negedge clk);
    reset_n = 1'b1;
    set_req(1, 13'h0005, 64'h3333_0000_0000_0000);
    serve_txn(expect_winner(1'b0, 1'b1), 0, 2, -1, -1, 1'b0, 64'hC0, obs, fwd);
  endtask

  task automatic test_idle_respcyc();
    logic [5:0] v;
    clear_all();
    respackV[0]    = 1'b1;
    respackV[1]    = 1'b1;
    drive_req();
    mem_if.respcyc = 1'b1;
    mem_if.resp    = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      v = {gnt, mem_if.bid, mem_if.respack, m0_if.respcyc, m1_if.respcyc};
      totalCnt++;
      if (v !== 6'b0) $display("[TB] FAIL idle_respcyc: got=%b expected=000000", v);
      else passCnt++;
    end
    clear_all();
  endtask

  task automatic test_random();
    int          obs, fwd, exp, guard;
    logic [1:0]  mask;
    logic [12:0] tag;
    for (int r = 0; r < 12; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        if (mask[i]) begin
          tag = 13'($urandom);
          set_req(i, tag, {$urandom, $urandom});
        end
      end
      guard = 0;
      while ((bidV[0] || bidV[1]) && guard < 4) begin
        exp = expect_winner(bidV[0], bidV[1]);
        serve_txn(exp, 0, 2, -1, -1, 1'b1, {$urandom, $urandom}, obs, fwd);
        guard++;
      end
      clear_all();
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_all();
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_drop_bid();
    test_reset_mid();
    test_idle_respcyc();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
